// File: rtl/breadboard_sweep_ctrl_if.sv
// Control/status bundle between the sweep requester (master) and breadboard_sweep_ctrl (slave).
interface breadboard_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic       first_fail_vld;

    modport master (
        output start, abort,
        input  busy, done, pass, err_count, first_fail, first_fail_vld
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, err_count, first_fail, first_fail_vld
    );
endinterface

// File: rtl/breadboard_sweep_ctrl.sv
// Exhaustive 16-vector sweep of the w,x,y,z -> f[9:0] breadboard block with result scoring.
// Optional capture RAM (rd_addr/rd_data) is built when SWEEP_CAPTURE_EN is defined.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; results from last sweep held
//   ST_DRIVE  | vector vec presented on w..z, settle timer loaded
//   ST_SETTLE | settle down-counter running
//   ST_SAMPLE | f compared against expected slice for vec
//   ST_DONE   | one-cycle completion, pass latched
module breadboard_sweep_ctrl #(
    parameter int             SETTLE    = 2,
    parameter logic [159:0]   EXP_TABLE = 160'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    breadboard_sweep_ctrl_if.slave ctl,
    input  logic [9:0]             f,
    output logic                   w,
    output logic                   x,
    output logic                   y,
    output logic                   z
`ifdef SWEEP_CAPTURE_EN
    ,
    input  logic [3:0]             rd_addr,
    output logic [9:0]             rd_data
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] vec;
    logic [3:0] drive_vec;
    logic [3:0] cnt;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic       first_fail_vld;
    logic       pass;
    logic       mismatch;
    logic       abort_hit;
    logic       start_ok;

    assign mismatch  = (f != EXP_TABLE[10*vec +: 10]);
    assign abort_hit = ctl.abort && (state != ST_IDLE);
    assign start_ok  = (state == ST_IDLE) && ctl.start && !ctl.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (cnt == 4'd0) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = (vec == 4'd15) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_hit) state_nxt = ST_IDLE;
    end

    // drive_vec is loaded on entry to DRIVE so w..z are stable for the whole DRIVE..SAMPLE window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec            <= 4'd0;
            drive_vec      <= 4'd0;
            cnt            <= 4'd0;
            err_count      <= 5'd0;
            first_fail     <= 4'd0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
        end else if (abort_hit) begin
            drive_vec <= 4'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        vec            <= 4'd0;
                        drive_vec      <= 4'd0;
                        err_count      <= 5'd0;
                        first_fail     <= 4'd0;
                        first_fail_vld <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                ST_DRIVE:  cnt <= SETTLE_LOAD;
                ST_SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != 5'd16) err_count <= err_count + 5'd1;
                        if (!first_fail_vld) begin
                            first_fail     <= vec;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (vec != 4'd15) begin
                        vec       <= vec + 4'd1;
                        drive_vec <= vec + 4'd1;
                    end
                end
                ST_DONE:   pass <= (err_count == 5'd0);
                default: ;
            endcase
        end
    end

`ifdef SWEEP_CAPTURE_EN
    logic [9:0] cap_mem [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) cap_mem[i] <= 10'd0;
        end else if (state == ST_SAMPLE && !ctl.abort) begin
            cap_mem[vec] <= f;
        end
    end

    assign rd_data = cap_mem[rd_addr];
`endif

    assign {w, x, y, z}       = drive_vec;
    assign ctl.busy           = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign ctl.done           = (state == ST_DONE);
    assign ctl.pass           = pass;
    assign ctl.err_count      = err_count;
    assign ctl.first_fail     = first_fail;
    assign ctl.first_fail_vld = first_fail_vld;

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Self-checking bench for breadboard_sweep_ctrl: SETTLE=2 instance with a matching model, SETTLE=0 instance with EXP_TABLE=0.
module tb_breadboard_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [9:0] bb_model(input logic [3:0] v);
        return {~v, v[1:0] ^ v[3:2], v};
    endfunction

    function automatic logic [159:0] build_table();
        logic [159:0] t;
        t = '0;
        for (int v = 0; v < 16; v++) t[10*v +: 10] = bb_model(4'(v));
        return t;
    endfunction

    localparam logic [159:0] EXP_A = build_table();

    breadboard_sweep_ctrl_if ia();
    breadboard_sweep_ctrl_if ib();

    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic       wa, xa, ya, za, wb, xb, yb, zb;
    logic [9:0] fa, fb;
    bit         inject = 1'b0;
    bit         b_mode = 1'b0;
    logic       sel_b = 1'b0;
    logic [3:0] rd_addr_a = 4'd0, rd_addr_b = 4'd0;
    logic [9:0] rd_data_a, rd_data_b;

    assign ia.start = start_a;
    assign ia.abort = abort_a;
    assign ib.start = start_b;
    assign ib.abort = abort_b;

    assign fa = bb_model({wa, xa, ya, za}) ^
                ((inject && ({wa, xa, ya, za} == 4'd5 || {wa, xa, ya, za} == 4'd12)) ? 10'h008 : 10'h000);
    assign fb = b_mode ? bb_model({wb, xb, yb, zb}) : 10'h3FF;

    breadboard_sweep_ctrl #(.SETTLE(2), .EXP_TABLE(EXP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ctl(ia), .f(fa),
        .w(wa), .x(xa), .y(ya), .z(za)
`ifdef SWEEP_CAPTURE_EN
        , .rd_addr(rd_addr_a), .rd_data(rd_data_a)
`endif
    );

    breadboard_sweep_ctrl #(.SETTLE(0), .EXP_TABLE(160'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ctl(ib), .f(fb),
        .w(wb), .x(xb), .y(yb), .z(zb)
`ifdef SWEEP_CAPTURE_EN
        , .rd_addr(rd_addr_b), .rd_data(rd_data_b)
`endif
    );

`ifndef SWEEP_CAPTURE_EN
    assign rd_data_a = 10'd0;
    assign rd_data_b = 10'd0;
`endif

    logic       cur_busy, cur_done, cur_pass, cur_ffv;
    logic [4:0] cur_err;
    logic [3:0] cur_ff, cur_vec;
    assign cur_busy = sel_b ? ib.busy : ia.busy;
    assign cur_done = sel_b ? ib.done : ia.done;
    assign cur_pass = sel_b ? ib.pass : ia.pass;
    assign cur_ffv  = sel_b ? ib.first_fail_vld : ia.first_fail_vld;
    assign cur_err  = sel_b ? ib.err_count : ia.err_count;
    assign cur_ff   = sel_b ? ib.first_fail : ia.first_fail;
    assign cur_vec  = sel_b ? {wb, xb, yb, zb} : {wa, xa, ya, za};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        bit         use_b;
        bit         inject;
        bit         b_mode;
        bit         repulse;
        int         exp_cycles;
        logic [4:0] exp_err;
        logic [3:0] exp_ff;
        bit         exp_ffv;
        bit         exp_pass;
    } vec_t;

    vec_t tbl[5];

    task automatic set_start(input logic v);
        if (sel_b) start_b = v; else start_a = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel_b) abort_b = v; else abort_a = v;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
    endtask

    task automatic run_sweep(input vec_t t);
        int  cycles;
        int  per;
        bit  walk_ok;
        sel_b  = t.use_b;
        inject = t.inject;
        b_mode = t.b_mode;
        cycles = -1;
        walk_ok = 1'b1;
        per = t.exp_cycles / 16;
        pulse_start();
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            set_start((t.repulse && n == 20) ? 1'b1 : 1'b0);
            if (cur_done) begin
                cycles = n;
                break;
            end
            if (!cur_busy || cur_vec != 4'(n / per)) walk_ok = 1'b0;
        end
        set_start(1'b0);
        check({t.name, "_done_cycle"}, cycles, t.exp_cycles);
        check({t.name, "_walk_busy"}, {31'd0, walk_ok}, 32'd1);
        check({t.name, "_err_count"}, {27'd0, cur_err}, {27'd0, t.exp_err});
        check({t.name, "_first_fail_vld"}, {31'd0, cur_ffv}, {31'd0, t.exp_ffv});
        if (t.exp_ffv) check({t.name, "_first_fail"}, {28'd0, cur_ff}, {28'd0, t.exp_ff});
        @(posedge clk);
        #1;
        check({t.name, "_pass"}, {31'd0, cur_pass}, {31'd0, t.exp_pass});
        check({t.name, "_done_one_cycle"}, {30'd0, cur_done, cur_busy}, 32'd0);
    endtask

    initial begin
        bit no_done;

        tbl[0] = '{"clean_a",   1'b0, 1'b0, 1'b0, 1'b0, 64, 5'd0,  4'd0, 1'b0, 1'b1};
        tbl[1] = '{"inject_a",  1'b0, 1'b1, 1'b0, 1'b0, 64, 5'd2,  4'd5, 1'b1, 1'b0};
        tbl[2] = '{"ones_b",    1'b1, 1'b0, 1'b0, 1'b0, 32, 5'd16, 4'd0, 1'b1, 1'b0};
        tbl[3] = '{"repulse_a", 1'b0, 1'b0, 1'b0, 1'b1, 64, 5'd0,  4'd0, 1'b0, 1'b1};
        tbl[4] = '{"model_b",   1'b1, 1'b0, 1'b1, 1'b0, 32, 5'd16, 4'd0, 1'b1, 1'b0};

        #22;
        check("rst_busy_done", {30'd0, ia.busy, ia.done}, 32'd0);
        check("rst_pass", {31'd0, ia.pass}, 32'd0);
        check("rst_err_count", {27'd0, ia.err_count}, 32'd0);
        check("rst_first_fail", {27'd0, ia.first_fail_vld, ia.first_fail}, 32'd0);
        check("rst_wxyz", {28'd0, wa, xa, ya, za}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

`ifdef SWEEP_CAPTURE_EN
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            rd_addr_b = 4'(v);
            #1;
            check($sformatf("capture_%0d", v), {22'd0, rd_data_b}, {22'd0, bb_model(4'(v))});
        end
`endif

        // abort while vector 7 is on the pins
        sel_b = 1'b0;
        inject = 1'b0;
        pulse_start();
        for (int n = 1; n <= 29; n++) begin
            @(posedge clk);
            #1;
        end
        check("abort_pre_vec", {28'd0, cur_vec}, 32'd7);
        set_abort(1'b1);
        @(posedge clk);
        #1;
        check("abort_busy_wxyz", {27'd0, cur_busy, cur_vec}, 32'd0);
        check("abort_no_done", {31'd0, cur_done}, 32'd0);
        @(negedge clk);
        set_abort(1'b0);
        no_done = 1'b1;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (cur_done || cur_busy) no_done = 1'b0;
        end
        check("abort_stays_idle", {31'd0, no_done}, 32'd1);
        check("abort_pass", {31'd0, cur_pass}, 32'd0);
        run_sweep(tbl[0]);

        // abort and start together in IDLE
        @(negedge clk);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk);
        #1;
        check("abort_start_idle", {31'd0, ia.busy}, 32'd0);
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        @(posedge clk);
        #1;
        check("abort_start_no_late", {31'd0, ia.busy}, 32'd0);

        // asynchronous reset mid-sweep
        inject = 1'b1;
        pulse_start();
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_err", {27'd0, ia.err_count}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", {27'd0, ia.busy, ia.done, ia.pass, ia.first_fail_vld, 1'b0}, 32'd0);
        check("async_rst_err_ff", {23'd0, ia.err_count, ia.first_fail}, 32'd0);
        check("async_rst_wxyz", {28'd0, wa, xa, ya, za}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        inject = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
